// File: rtl/l2_mem_pkg.sv
// Shared types and sizes for the L2 memory initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package l2_mem_pkg;

  localparam int L2_DATA_WIDTH = 64;
  localparam int L2_BE_WIDTH   = 8;
  localparam int L2_RSP_DEPTH  = 2;

  // CLEAR only exists when the boot-time zero-fill engine is compiled in.
  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } l2_state_e;

endpackage

// File: rtl/UNICAD_MEM_BUS_64.sv
// 64-bit single-port SRAM bus; the slave returns rdata one cycle after a read.
// Latency: read data valid in the cycle after csn=0, wen=1.
// Backpressure: none, the SRAM accepts one access per cycle.
// Signals: csn (active-low select), wen (0 = write), ben (byte enables),
//          add (word address), wdata, rdata.
interface UNICAD_MEM_BUS_64 #(
  parameter int ADDR_WIDTH = 15
);
  logic                  csn;
  logic                  wen;
  logic [7:0]            ben;
  logic [ADDR_WIDTH-1:0] add;
  logic [63:0]           wdata;
  logic [63:0]           rdata;

  modport Master (output csn, wen, ben, add, wdata, input rdata);
  modport Slave  (input csn, wen, ben, add, wdata, output rdata);
endinterface

// File: rtl/l2_rsp_fifo.sv
// 2-entry in-order read-response buffer.
// Latency: push visible at the head in the next cycle.
// Backpressure: head held stable until pop; push while full is dropped unless popping.
// Ports: clk, rst_n (async active-low), push/push_dat in, pop in,
//        head_dat out (oldest entry), full/empty out.
module l2_rsp_fifo
  import l2_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [L2_DATA_WIDTH-1:0] push_dat,
  input  logic                     pop,
  output logic [L2_DATA_WIDTH-1:0] head_dat,
  output logic                     full,
  output logic                     empty
);

  logic [L2_DATA_WIDTH-1:0] mem_q [L2_RSP_DEPTH];
  logic                     wr_ptr_q;
  logic                     rd_ptr_q;
  logic [1:0]               cnt_q;
  logic                     do_push;
  logic                     do_pop;

  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L2_RSP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/l2_mem_initiator.sv
// Turns a req/gnt/r_valid stream into single-cycle L2 SRAM accesses, with optional boot zero-fill.
// Latency: bus driven in the grant cycle; read data on r_valid_o two cycles after grant.
// Backpressure: gnt_o withheld while granted-but-unconsumed reads would exceed the 2-entry buffer.
// Ports: clk_i, rst_ni (async active-low); req_i/add_i/wen_i/wdata_i/be_i -> gnt_o;
//        r_valid_o/r_rdata_o <- r_ready_i; init_done_o; mem_master drives the SRAM bus.
// Build option: L2_INIT_CLEAR_EN adds the CLEAR state that zero-fills every word after reset.
module l2_mem_initiator
  import l2_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 15,
  parameter int BE_WIDTH       = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic [31:0]              add_i,
  input  logic                     wen_i,
  input  logic [L2_DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]      be_i,
  output logic                     gnt_o,
  output logic                     r_valid_o,
  output logic [L2_DATA_WIDTH-1:0] r_rdata_o,
  input  logic                     r_ready_i,
  output logic                     init_done_o,
  UNICAD_MEM_BUS_64.Master         mem_master
);

`ifdef L2_INIT_CLEAR_EN
  localparam l2_state_e RST_STATE = CLEAR;
  logic [MEM_ADDR_WIDTH-1:0] clr_cnt_q;
`else
  localparam l2_state_e RST_STATE = SERVE;
`endif

  l2_state_e                 state_q, state_d;
  logic                      inflight_q;
  logic [MEM_ADDR_WIDTH-1:0] add_q;
  logic [L2_DATA_WIDTH-1:0]  wdata_q;

  logic                      grant;
  logic                      acc;
  logic                      acc_wen;
  logic [BE_WIDTH-1:0]       acc_ben;
  logic [MEM_ADDR_WIDTH-1:0] acc_add;
  logic [L2_DATA_WIDTH-1:0]  acc_wdata;
  logic                      live_acc;

  logic                      rsp_full, rsp_empty, rsp_pop;
  logic [1:0]                rsp_occ;
  logic                      room;
  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  logic                      unused_add_bits;

  assign word_idx        = add_i[MEM_ADDR_WIDTH+2:3];
  assign unused_add_bits = ^{add_i[2:0], add_i[31:MEM_ADDR_WIDTH+3]};

  assign r_valid_o = ~rsp_empty;
  assign rsp_pop   = r_valid_o & r_ready_i;
  assign rsp_occ   = {rsp_full, ~rsp_full & ~rsp_empty};
  // Buffered + in-flight reads, less the one leaving this cycle, must stay below 2.
  assign room = ({1'b0, rsp_occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, rsp_pop});

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    acc       = 1'b0;
    acc_wen   = 1'b1;
    acc_ben   = '0;
    acc_add   = add_q;
    acc_wdata = wdata_q;
    case (state_q)
      CLEAR: begin
`ifdef L2_INIT_CLEAR_EN
        acc       = 1'b1;
        acc_wen   = 1'b0;
        acc_ben   = {L2_BE_WIDTH{1'b1}};
        acc_add   = clr_cnt_q;
        acc_wdata = '0;
        if (clr_cnt_q == {MEM_ADDR_WIDTH{1'b1}}) state_d = SERVE;
`else
        state_d = SERVE;
`endif
      end
      SERVE: begin
        grant = req_i & room;
        if (grant) begin
          acc       = 1'b1;
          acc_wen   = wen_i;
          acc_ben   = be_i;
          acc_add   = word_idx;
          acc_wdata = wdata_i;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RST_STATE;
      inflight_q <= 1'b0;
      add_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= grant & wen_i;
      if (acc) begin
        add_q   <= acc_add;
        wdata_q <= acc_wdata;
      end
    end
  end

`ifdef L2_INIT_CLEAR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) clr_cnt_q <= '0;
    else if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
  end
`endif

  // The state register sits in an active state during reset, so the outputs are
  // forced idle by rst_ni itself to show reset values while reset is held.
  assign live_acc         = acc & rst_ni;
  assign gnt_o            = grant & rst_ni;
  assign init_done_o      = (state_q == SERVE) & rst_ni;
  assign mem_master.csn   = ~live_acc;
  assign mem_master.wen   = live_acc ? acc_wen : 1'b1;
  assign mem_master.ben   = live_acc ? acc_ben : '0;
  assign mem_master.add   = live_acc ? acc_add : add_q;
  assign mem_master.wdata = live_acc ? acc_wdata : wdata_q;

  l2_rsp_fifo u_rsp_fifo (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (inflight_q),
    .push_dat (mem_master.rdata),
    .pop      (rsp_pop),
    .head_dat (r_rdata_o),
    .full     (rsp_full),
    .empty    (rsp_empty)
  );

endmodule

// File: doc/l2_mem_initiator.md
# l2_mem_initiator

Master-side controller for the 64-bit L2 SRAM bus (UNICAD_MEM_BUS_64). It turns a req/gnt/r_valid request stream from the SoC interconnect into single-cycle SRAM accesses. Read data is returned through a 2-entry response buffer that honours consumer backpressure. An optional boot-time engine zero-fills the whole L2 before the first request is granted.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 15, SRAM word-address width (2^15 words of 64 bit).
- BE_WIDTH, 8, byte enables per word (fixed; DATA is 64 bit).

Ports:
- clk_i  in  1  single clock; all logic rising-edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  request valid.
- add_i  in  32  byte address; word index = add_i[MEM_ADDR_WIDTH+2:3]; add_i[2:0] and bits above MEM_ADDR_WIDTH+2 are ignored.
- wen_i  in  1  0 = write, 1 = read.
- wdata_i  in  64  write data.
- be_i  in  8  byte enables, 1 = byte written.
- gnt_o  out  1  request accepted this cycle.
- r_valid_o  out  1  read response valid.
- r_rdata_o  out  64  read response data.
- r_ready_i  in  1  consumer accepts the response.
- init_done_o  out  1  high once serving requests.
- mem_master  UNICAD_MEM_BUS_64.Master  drives csn, wen, ben, add, wdata; samples rdata one cycle after a read.

## Operation
- FSM states:
  - CLEAR: entered on reset when the clear engine is compiled in. Writes zero to word addresses 0 .. 2^MEM_ADDR_WIDTH-1, one per cycle, with ben=8'hFF. gnt_o=0.
  - SERVE: entered from CLEAR after the last address is written. init_done_o=1 while in SERVE.
- Grant rule in SERVE: gnt_o = req_i & (occ + inflight − pop < 2).
  - occ: response-buffer occupancy (0..2).
  - inflight: 1 if a read was issued the previous cycle.
  - pop: r_valid_o & r_ready_i.
- Granted access drives the bus combinationally in the same cycle:
  - csn=0, wen=wen_i, ben=be_i, add=word index, wdata=wdata_i.
  - Ungranted cycle: csn=1, wen=1, ben=0; add and wdata hold their last values.
- Writes produce no response.
- Reads: mem_master.rdata is captured into the response FIFO at the end of the cycle after issue. FIFO is 2 entries, in order, and data is stable while r_valid_o=1 & r_ready_i=0.
- Push and pop in the same cycle with occ=2 is legal; the grant rule prevents overflow.
- Reset mid-operation:
  - In-flight read and FIFO contents are discarded.
  - CLEAR restarts at address 0.

## Timing
- Read latency: grant in cycle N, r_valid_o first high in cycle N+2.
- Back-to-back reads with r_ready_i=1: one grant per cycle, one response per cycle.
- Write: SRAM updated at the end of the grant cycle. A read granted in the next cycle returns the new data.
- CLEAR duration: 2^MEM_ADDR_WIDTH cycles after reset release; init_done_o rises in the following cycle.
- Reset values: gnt_o=0, r_valid_o=0, r_rdata_o=0, init_done_o=0, csn=1, wen=1, ben=0, add=0, wdata=0. Address counter and FIFO pointers are 0.

## Configuration
- L2_INIT_CLEAR_EN:
  - Defined: CLEAR state and a MEM_ADDR_WIDTH-bit counter are built; the FSM leaves reset in CLEAR.
  - Undefined: no CLEAR state; the FSM leaves reset in SERVE and init_done_o=1 from the first cycle after reset release.

## Structure
- Shared package l2_mem_pkg holds:
  - typedef l2_state_e {CLEAR, SERVE};
  - L2_DATA_WIDTH=64, L2_BE_WIDTH=8, L2_RSP_DEPTH=2.
- One sub-module, l2_rsp_fifo: 2-entry, 64-bit, push/pop/full/empty, async active-low reset.

## Test plan
- Clear (MEM_ADDR_WIDTH=4, macro defined) → exactly 16 writes, add 0..15, wdata=0, ben=FF, gnt_o=0 throughout; init_done_o rises on cycle 17.
- Write 64'hDEAD_BEEF_0123_4567 to byte address 0x18 with be=8'h0F, then read 0x18 → r_rdata_o=64'h0000_0000_0123_4567 two cycles after the read grant.
- 8 back-to-back reads with r_ready_i=1 → 8 grants in 8 consecutive cycles and 8 in-order responses.
- Hold r_ready_i=0 during streaming reads → at most 2 unconsumed reads outstanding, gnt_o drops, and r_rdata_o stays stable. Release r_ready_i → no response lost or duplicated.
- Assert rst_ni low midway through CLEAR and mid-read → outputs return to reset values immediately, no response is emitted for the aborted read, and CLEAR restarts at address 0.
- Macro undefined → init_done_o=1 and a request is granted in the first cycle after reset release.
